// File: rtl/draw_pkg.sv
// draw_pkg: shared types and constants for the sprite draw scheduler.
//   - screen geometry of the 160x120 frame buffer
//   - default 3-bit colours
//   - position typedefs (x 8-bit, y 7-bit) and a packed position struct
//   - scheduler state enum
package draw_pkg;

   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;

   localparam logic [2:0] DEF_COL_BG       = 3'b000;
   localparam logic [2:0] DEF_COL_PLAYER   = 3'b100;
   localparam logic [2:0] DEF_COL_OBSTACLE = 3'b001;
   localparam logic [2:0] DEF_COL_GAMEOVER = 3'b110;

   typedef logic [7:0] pos_x_t;
   typedef logic [6:0] pos_y_t;

   typedef struct packed {
      pos_x_t x;
      pos_y_t y;
   } pos_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LATCH,
      ST_ERASE_P,
      ST_DRAW_P,
      ST_ERASE_O,
      ST_DRAW_O,
      ST_CLEAR,
      ST_DONE
   } state_e;

endpackage

// File: rtl/sprite_scan.sv
// sprite_scan: pixel address generator shared by every sprite pass and the
// full-screen clear.
//   clock, reset   : clock, async active-high reset
//   start          : zero all counters (held while the scheduler is idle/latching)
//   advance        : step to the next pixel
//   clear_mode     : 1 = raster scan of the whole screen, 0 = sprite offset scan
//   base_x, base_y : sprite top-left corner
//   px, py         : current pixel address (low bits of the clipped sum)
//   in_bounds      : current pixel lies on screen
//   last           : current pixel is the final one of the scan
module sprite_scan
   import draw_pkg::*;
#(
   parameter int SPRITE_LOG2 = 2
) (
   input  logic   clock,
   input  logic   reset,
   input  logic   start,
   input  logic   advance,
   input  logic   clear_mode,
   input  pos_x_t base_x,
   input  pos_y_t base_y,
   output pos_x_t px,
   output pos_y_t py,
   output logic   in_bounds,
   output logic   last
);

   localparam int KW = 2 * SPRITE_LOG2;

   logic [KW-1:0]          k_q, k_d;
   pos_x_t                 cx_q, cx_d;
   pos_y_t                 cy_q, cy_d;
   logic [SPRITE_LOG2-1:0] dx, dy;
   logic [8:0]             sum_x;
   logic [7:0]             sum_y;

   always_comb begin
      dx = k_q[SPRITE_LOG2-1:0];
      dy = k_q[KW-1:SPRITE_LOG2];
      // Sums are one bit wider than the screen coordinate so a sprite hanging
      // off the right/bottom edge is clipped rather than wrapped.
      if (clear_mode) begin
         sum_x = {1'b0, cx_q};
         sum_y = {1'b0, cy_q};
      end else begin
         sum_x = {1'b0, base_x} + 9'(dx);
         sum_y = {1'b0, base_y} + 8'(dy);
      end
      px        = sum_x[7:0];
      py        = sum_y[6:0];
      in_bounds = (sum_x < 9'(SCREEN_W)) && (sum_y < 8'(SCREEN_H));
      if (clear_mode)
         last = (cx_q == 8'(SCREEN_W - 1)) && (cy_q == 7'(SCREEN_H - 1));
      else
         last = (k_q == {KW{1'b1}});
   end

   always_comb begin
      k_d  = k_q;
      cx_d = cx_q;
      cy_d = cy_q;
      if (start) begin
         k_d  = '0;
         cx_d = '0;
         cy_d = '0;
      end else if (advance) begin
         if (clear_mode) begin
            if (cx_q == 8'(SCREEN_W - 1)) begin
               cx_d = '0;
               cy_d = (cy_q == 7'(SCREEN_H - 1)) ? '0 : cy_q + 7'd1;
            end else begin
               cx_d = cx_q + 8'd1;
            end
         end else begin
            // natural wrap returns k to 0 for the next pass
            k_d = k_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         k_q  <= '0;
         cx_q <= '0;
         cy_q <= '0;
      end else begin
         k_q  <= k_d;
         cx_q <= cx_d;
         cy_q <= cy_d;
      end
   end

endmodule

// File: rtl/sprite_draw_scheduler.sv
// sprite_draw_scheduler: sole write master of the VGA frame buffer. A frame
// request erases player/obstacle at their previous positions and redraws them
// at the latched new positions; a clear request fills the screen with COL_BG.
//   clock, reset             : clock, async active-high reset
//   frame_start, clear_req   : single-cycle requests (clear wins when both)
//   player_*, obstacle_*     : sprite top-left positions, latched per frame
//   gameover                 : latched per frame, recolours the player
//   x, y, colour, plot       : registered adapter write port
//   busy                     : not idle
//   done                     : one-cycle completion pulse
//   overrun                  : sticky, request seen while busy
module sprite_draw_scheduler
   import draw_pkg::*;
#(
   parameter int         SPRITE_LOG2  = 2,
   parameter logic [2:0] COL_BG       = DEF_COL_BG,
   parameter logic [2:0] COL_PLAYER   = DEF_COL_PLAYER,
   parameter logic [2:0] COL_OBSTACLE = DEF_COL_OBSTACLE,
   parameter logic [2:0] COL_GAMEOVER = DEF_COL_GAMEOVER
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       frame_start,
   input  logic       clear_req,
   input  logic [7:0] player_x,
   input  logic [6:0] player_y,
   input  logic [7:0] obstacle_x,
   input  logic [6:0] obstacle_y,
   input  logic       gameover,
   output logic [7:0] x,
   output logic [6:0] y,
   output logic [2:0] colour,
   output logic       plot,
   output logic       busy,
   output logic       done,
   output logic       overrun
);

   state_e     state_q, state_d;
   pos_t       new_p_q, new_p_d, new_o_q, new_o_d;
   pos_t       old_p_q, old_p_d, old_o_q, old_o_d;
   logic       old_valid_q, old_valid_d;
   logic       go_q, go_d;
   logic       clr_op_q, clr_op_d;     // current job is a clear, not a frame
   logic       clr_tail_q, clr_tail_d; // final clear pixel issued, draining
   logic       overrun_q, overrun_d;
   pos_x_t     x_q, x_d;
   pos_y_t     y_q, y_d;
   logic [2:0] colour_q, colour_d;
   logic       plot_q, plot_d;

   logic       scan_start, scan_adv;
   pos_t       base;
   logic [2:0] pass_col;
   pos_x_t     px;
   pos_y_t     py;
   logic       in_bounds, scan_last;

   sprite_scan #(.SPRITE_LOG2(SPRITE_LOG2)) u_scan (
      .clock      (clock),
      .reset      (reset),
      .start      (scan_start),
      .advance    (scan_adv),
      .clear_mode (state_q == ST_CLEAR),
      .base_x     (base.x),
      .base_y     (base.y),
      .px         (px),
      .py         (py),
      .in_bounds  (in_bounds),
      .last       (scan_last)
   );

   assign busy    = (state_q != ST_IDLE);
   assign done    = (state_q == ST_DONE);
   assign overrun = overrun_q;
   assign x       = x_q;
   assign y       = y_q;
   assign colour  = colour_q;
   assign plot    = plot_q;

   // Per-pass position and colour
   always_comb begin
      base     = new_o_q;
      pass_col = COL_OBSTACLE;
      case (state_q)
         ST_ERASE_P: begin base = old_p_q; pass_col = COL_BG; end
         ST_DRAW_P:  begin base = new_p_q; pass_col = go_q ? COL_GAMEOVER : COL_PLAYER; end
         ST_ERASE_O: begin base = old_o_q; pass_col = COL_BG; end
         default:    ;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      new_p_d     = new_p_q;
      new_o_d     = new_o_q;
      old_p_d     = old_p_q;
      old_o_d     = old_o_q;
      old_valid_d = old_valid_q;
      go_d        = go_q;
      clr_op_d    = clr_op_q;
      clr_tail_d  = clr_tail_q;
      overrun_d   = overrun_q;
      x_d         = x_q;
      y_d         = y_q;
      colour_d    = colour_q;
      plot_d      = 1'b0;
      scan_start  = 1'b0;
      scan_adv    = 1'b0;

      if ((frame_start || clear_req) && (state_q != ST_IDLE))
         overrun_d = 1'b1;

      case (state_q)
         ST_IDLE: begin
            scan_start = 1'b1;
            if (clear_req) begin
               state_d  = ST_CLEAR;
               clr_op_d = 1'b1;
            end else if (frame_start) begin
               state_d  = ST_LATCH;
               clr_op_d = 1'b0;
            end
         end
         ST_LATCH: begin
            scan_start = 1'b1;
            new_p_d    = '{x: player_x, y: player_y};
            new_o_d    = '{x: obstacle_x, y: obstacle_y};
            go_d       = gameover;
            state_d    = old_valid_q ? ST_ERASE_P : ST_DRAW_P;
         end
         ST_ERASE_P, ST_DRAW_P, ST_ERASE_O, ST_DRAW_O: begin
            // off-screen pixels still take their cycle, just without plot
            scan_adv = 1'b1;
            plot_d   = in_bounds;
            x_d      = px;
            y_d      = py;
            colour_d = pass_col;
            if (scan_last) begin
               case (state_q)
                  ST_ERASE_P: state_d = ST_DRAW_P;
                  ST_DRAW_P:  state_d = old_valid_q ? ST_ERASE_O : ST_DRAW_O;
                  ST_ERASE_O: state_d = ST_DRAW_O;
                  default:    state_d = ST_DONE;
               endcase
            end
         end
         ST_CLEAR: begin
            // One drain cycle after the last raster pixel so done follows the
            // final plot rather than coinciding with it.
            if (clr_tail_q) begin
               clr_tail_d  = 1'b0;
               old_valid_d = 1'b0;
               overrun_d   = 1'b0;
               state_d     = ST_DONE;
            end else begin
               scan_adv = 1'b1;
               plot_d   = 1'b1;
               x_d      = px;
               y_d      = py;
               colour_d = COL_BG;
               if (scan_last) clr_tail_d = 1'b1;
            end
         end
         ST_DONE: begin
            if (!clr_op_q) begin
               old_p_d     = new_p_q;
               old_o_d     = new_o_q;
               old_valid_d = 1'b1;
            end
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         new_p_q     <= '0;
         new_o_q     <= '0;
         old_p_q     <= '0;
         old_o_q     <= '0;
         old_valid_q <= 1'b0;
         go_q        <= 1'b0;
         clr_op_q    <= 1'b0;
         clr_tail_q  <= 1'b0;
         overrun_q   <= 1'b0;
         x_q         <= '0;
         y_q         <= '0;
         colour_q    <= '0;
         plot_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         new_p_q     <= new_p_d;
         new_o_q     <= new_o_d;
         old_p_q     <= old_p_d;
         old_o_q     <= old_o_d;
         old_valid_q <= old_valid_d;
         go_q        <= go_d;
         clr_op_q    <= clr_op_d;
         clr_tail_q  <= clr_tail_d;
         overrun_q   <= overrun_d;
         x_q         <= x_d;
         y_q         <= y_d;
         colour_q    <= colour_d;
         plot_q      <= plot_d;
      end
   end

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
module tb_sprite_draw_scheduler;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       frame_start = 1'b0, clear_req = 1'b0, gameover = 1'b0;
   logic [7:0] player_x = '0, obstacle_x = '0;
   logic [6:0] player_y = '0, obstacle_y = '0;
   logic [7:0] x;
   logic [6:0] y;
   logic [2:0] colour;
   logic       plot, busy, done, overrun;

   sprite_draw_scheduler dut (
      .clock(clock), .reset(reset), .frame_start(frame_start), .clear_req(clear_req),
      .player_x(player_x), .player_y(player_y), .obstacle_x(obstacle_x),
      .obstacle_y(obstacle_y), .gameover(gameover), .x(x), .y(y), .colour(colour),
      .plot(plot), .busy(busy), .done(done), .overrun(overrun)
   );

   always #5 clock = ~clock;

   // Expected output of one cycle; an empty queue means "idle".
   typedef struct {
      bit busy; bit done; bit plot; bit clr;
      int x; int y; int c;
   } exp_t;
   typedef struct { int x; int y; int c; bit p; } pix_t;

   exp_t exp_q[$];
   pix_t pix_q[$];

   int n_chk = 0, n_fail = 0, cyc = 0;
   bit cur_busy = 0, m_ovr = 0, m_old_valid = 0;
   int m_old_px, m_old_py, m_old_ox, m_old_oy;
   int t_req, done_cyc, pcount, first_x, first_y, first_c, last_x, last_y;

   task automatic chk(input string nm, input int act, input int expv);
      n_chk++;
      if (act != expv) begin
         n_fail++;
         $display("FAIL %s cyc=%0d actual=%0d expected=%0d", nm, cyc, act, expv);
      end
   endtask

   // One clock: advance to the negedge and compare the cycle just entered.
   task automatic tick();
      bit   rb;
      exp_t e;
      rb = (frame_start || clear_req) && cur_busy;
      @(negedge clock);
      cyc++;
      if (reset) begin
         cur_busy = 0;
      end else begin
         if (rb) m_ovr = 1;
         if (exp_q.size() > 0) e = exp_q.pop_front();
         else begin
            e.busy = 0; e.done = 0; e.plot = 0; e.clr = 0; e.x = 0; e.y = 0; e.c = 0;
         end
         if (e.clr) m_ovr = 0;
         chk("busy", int'(busy), int'(e.busy));
         chk("done", int'(done), int'(e.done));
         chk("plot", int'(plot), int'(e.plot));
         chk("overrun", int'(overrun), int'(m_ovr));
         if (e.plot) begin
            chk("x", int'(x), e.x);
            chk("y", int'(y), e.y);
            chk("colour", int'(colour), e.c);
         end
         cur_busy = e.busy;
         if (plot === 1'b1) begin
            if (pcount == 0) begin first_x = int'(x); first_y = int'(y); first_c = int'(colour); end
            last_x = int'(x); last_y = int'(y);
            pcount++;
         end
         if (done === 1'b1) done_cyc = cyc;
      end
   endtask

   task automatic add_sprite(input int bx, input int by, input int c);
      pix_t p;
      for (int dy = 0; dy < 4; dy++)
         for (int dx = 0; dx < 4; dx++) begin
            p.x = bx + dx; p.y = by + dy; p.c = c;
            p.p = (p.x < 160) && (p.y < 120);
            pix_q.push_back(p);
         end
   endtask

   // Job = busy cycles 1..len; pixel j shows at cycle j+off; done on cycle len.
   task automatic push_job(input int off, input bit clr);
      exp_t e;
      int   len, j;
      len = pix_q.size() + 2;
      for (int i = 1; i <= len; i++) begin
         e.busy = 1; e.done = (i == len); e.clr = clr && (i == len);
         j = i - off;
         e.plot = 0; e.x = 0; e.y = 0; e.c = 0;
         if (j >= 0 && j < pix_q.size()) begin
            e.plot = pix_q[j].p; e.x = pix_q[j].x; e.y = pix_q[j].y; e.c = pix_q[j].c;
         end
         exp_q.push_back(e);
      end
   endtask

   task automatic start_stats();
      t_req = cyc; done_cyc = -1; pcount = 0;
      first_x = -1; first_y = -1; first_c = -1; last_x = -1; last_y = -1;
   endtask

   task automatic req_frame(input int px, input int py, input int ox, input int oy, input bit go);
      pix_q.delete();
      if (m_old_valid) add_sprite(m_old_px, m_old_py, 0);
      add_sprite(px, py, go ? 6 : 4);
      if (m_old_valid) add_sprite(m_old_ox, m_old_oy, 0);
      add_sprite(ox, oy, 1);
      push_job(3, 0);
      m_old_valid = 1; m_old_px = px; m_old_py = py; m_old_ox = ox; m_old_oy = oy;
      start_stats();
      player_x = 8'(px); player_y = 7'(py); obstacle_x = 8'(ox); obstacle_y = 7'(oy);
      gameover = go; frame_start = 1;
      tick();
      frame_start = 0;
   endtask

   task automatic req_clear(input bit with_frame);
      pix_t p;
      pix_q.delete();
      for (int yy = 0; yy < 120; yy++)
         for (int xx = 0; xx < 160; xx++) begin
            p.x = xx; p.y = yy; p.c = 0; p.p = 1;
            pix_q.push_back(p);
         end
      push_job(2, 1);
      m_old_valid = 0;
      start_stats();
      clear_req = 1; frame_start = with_frame;
      tick();
      clear_req = 0; frame_start = 0;
   endtask

   // Run to the end of the job, then spend the idle cycle after done.
   task automatic wait_done();
      int n = 0;
      while (exp_q.size() > 0 && n < 25000) begin tick(); n++; end
      if (exp_q.size() > 0) begin
         n_chk++; n_fail++;
         $display("FAIL timeout cyc=%0d actual=%0d expected=0 pending cycles", cyc, exp_q.size());
         exp_q.delete();
      end
      tick();
   endtask

   initial begin
      // reset state
      #1;
      chk("rst_x", int'(x), 0);       chk("rst_y", int'(y), 0);
      chk("rst_colour", int'(colour), 0);
      chk("rst_plot", int'(plot), 0); chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0); chk("rst_overrun", int'(overrun), 0);
      tick(); tick();
      reset = 0;
      tick();

      // first frame: no erase passes
      req_frame(20, 60, 150, 100, 0);
      wait_done();
      chk("A_latency", done_cyc - t_req, 34);
      chk("A_plots", pcount, 32);
      chk("A_first_x", first_x, 20); chk("A_first_y", first_y, 60);
      chk("A_first_col", first_c, 4);

      // second frame: erase at old player position first
      req_frame(20, 58, 150, 100, 0);
      wait_done();
      chk("B_latency", done_cyc - t_req, 66);
      chk("B_plots", pcount, 64);
      chk("B_first_x", first_x, 20); chk("B_first_y", first_y, 60);
      chk("B_first_col", first_c, 0);

      // clipped obstacle, game-over colour, request mid-frame
      req_frame(20, 58, 158, 118, 1);
      repeat (10) tick();
      frame_start = 1;
      tick();
      frame_start = 0;
      wait_done();
      chk("C_latency", done_cyc - t_req, 66);
      chk("C_plots", pcount, 52);
      chk("C_last_x", last_x, 159); chk("C_last_y", last_y, 119);
      chk("C_overrun_sticky", int'(overrun), 1);

      // clear wins over simultaneous frame request
      req_clear(1);
      wait_done();
      chk("CLR_latency", done_cyc - t_req, 19202);
      chk("CLR_plots", pcount, 19200);
      chk("CLR_first_x", first_x, 0);   chk("CLR_first_y", first_y, 0);
      chk("CLR_last_x", last_x, 159);   chk("CLR_last_y", last_y, 119);
      chk("CLR_overrun", int'(overrun), 0);

      // frame after clear skips erases
      req_frame(40, 40, 100, 50, 0);
      wait_done();
      chk("D_latency", done_cyc - t_req, 34);

      // reset while DRAW_O is plotting
      req_frame(41, 40, 100, 50, 0);
      repeat (54) tick();
      #2 reset = 1;
      #1;
      chk("E_rst_plot", int'(plot), 0);
      chk("E_rst_busy", int'(busy), 0);
      chk("E_rst_done", int'(done), 0);
      exp_q.delete();
      m_old_valid = 0; m_ovr = 0;
      tick(); tick();
      reset = 0;
      tick();

      // frame after reset skips erases again
      req_frame(30, 30, 60, 40, 0);
      wait_done();
      chk("F_latency", done_cyc - t_req, 34);
      chk("F_first_col", first_c, 4);
      chk("F_first_x", first_x, 30);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
